float_normalize: RTL and testbench

- Post-add normaliser for the parametrised float datapath.
- Takes the sign, the larger biased exponent and the raw sum mantissa from the add/sub stage (whose operands are already ordered so the exponent of lhs is at least that of rhs).
- Renormalises the mantissa, which is the inverse of the pre-add alignment shift, and packs a float {sign, exp, frac}.
- Multi-cycle, with a valid/ready handshake on both sides; one operation in flight at a time.

---
 rtl/float_pkg.sv | 18 +
 rtl/float_lzc.sv | 27 ++
 rtl/float_normalize.sv | 203 ++++++++++++++++++++
 tb/tb_float_normalize.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/float_pkg.sv
// Shared types and sizing helpers for the float normaliser slice.
package float_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic int float_width(input int exp_w, input int man_w);
    return exp_w + man_w + 1;
  endfunction

  function automatic int unsigned exp_ones(input int exp_w);
    return (32'd1 << exp_w) - 32'd1;
  endfunction

endpackage

// File: rtl/float_lzc.sv
// Combinational leading-zero counter; an all-zero vector reports WIDTH.
module float_lzc #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [CNT_W-1:0] count_o
);

  logic found_s;

  // Scan from the MSB, counting zeros until the first set bit.
  always_comb begin
    count_o = {CNT_W{1'b0}};
    found_s = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (found_s) begin
        count_o = count_o;
      end else if (vec_i[i]) begin
        found_s = 1'b1;
      end else begin
        count_o = count_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/float_normalize.sv
// Post-add normaliser: renormalises the raw sum mantissa and packs {sign, exp, frac}.
// Define FLOAT_NORM_FAST_EN for a single-cycle LZC-based left shift.
module float_normalize
  import float_pkg::*;
#(
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 7,
  localparam int FLOAT_WIDTH = float_width(EXP_WIDTH, MAN_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sign,
  input  logic [EXP_WIDTH-1:0]   in_exp,
  input  logic [MAN_WIDTH+1:0]   in_man,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [FLOAT_WIDTH-1:0] out_result,
  output logic                   out_overflow,
  output logic                   out_zero
);

  localparam logic [EXP_WIDTH-1:0] EXP_ONES = EXP_WIDTH'(exp_ones(EXP_WIDTH));
  localparam logic [EXP_WIDTH-1:0] EXP_ONE  = EXP_WIDTH'(1);
  localparam logic [EXP_WIDTH-1:0] EXP_ZERO = {EXP_WIDTH{1'b0}};
  localparam logic [MAN_WIDTH:0]   MAN_ZERO = {(MAN_WIDTH + 1){1'b0}};
  localparam logic [MAN_WIDTH+1:0] RAW_ZERO = {(MAN_WIDTH + 2){1'b0}};

  state_e               state_q, state_d;
  logic                 sign_q, sign_d;
  logic [EXP_WIDTH-1:0] exp_q, exp_d;
  logic [MAN_WIDTH:0]   man_q, man_d;
  logic                 ovf_q, ovf_d;
  logic                 zero_q, zero_d;
  logic                 valid_q, valid_d;

  logic [EXP_WIDTH-1:0] carry_exp_s;
  logic [MAN_WIDTH:0]   carry_man_s;
  logic [EXP_WIDTH-1:0] shift_exp_s;
  logic [MAN_WIDTH:0]   shift_man_s;
  logic                 shift_done_s;

`ifdef FLOAT_NORM_FAST_EN
  localparam int LZ_W = $clog2(MAN_WIDTH + 2);

  logic [LZ_W-1:0]      lz_s;
  logic [EXP_WIDTH-1:0] lz_ext_s;
  logic [EXP_WIDTH-1:0] exp_m1_s;
  logic [EXP_WIDTH-1:0] amt_s;
  logic [MAN_WIDTH:0]   fast_man_s;

  float_lzc #(
    .WIDTH (MAN_WIDTH + 1)
  ) u_lzc (
    .vec_i   (man_q),
    .count_o (lz_s)
  );

  // Whole shift in one step, clamped so the exponent never drops below 1.
  always_comb begin
    lz_ext_s     = EXP_WIDTH'(lz_s);
    exp_m1_s     = exp_q - EXP_ONE;
    if (lz_ext_s < exp_m1_s) begin
      amt_s = lz_ext_s;
    end else begin
      amt_s = exp_m1_s;
    end
    fast_man_s   = man_q << amt_s;
    shift_man_s  = fast_man_s;
    shift_done_s = 1'b1;
    if (fast_man_s[MAN_WIDTH]) begin
      shift_exp_s = exp_q - amt_s;
    end else begin
      shift_exp_s = EXP_ZERO;
    end
  end
`else
  // One-bit shift step; reaching exponent 1 without a hidden bit yields a denormal.
  always_comb begin
    shift_man_s  = man_q;
    shift_exp_s  = exp_q;
    shift_done_s = 1'b1;
    if (exp_q == EXP_ONE) begin
      shift_exp_s = EXP_ZERO;
    end else begin
      shift_man_s  = {man_q[MAN_WIDTH-1:0], 1'b0};
      shift_exp_s  = exp_q - EXP_ONE;
      shift_done_s = man_q[MAN_WIDTH-1];
    end
  end
`endif

  // Next-state and datapath update for the IDLE/SHIFT/DONE sequence.
  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    man_d       = man_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    valid_d     = valid_q;
    carry_exp_s = in_exp + EXP_ONE;
    carry_man_s = in_man[MAN_WIDTH+1:1];
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = in_sign;
          exp_d   = in_exp;
          man_d   = in_man[MAN_WIDTH:0];
          ovf_d   = 1'b0;
          zero_d  = 1'b0;
          valid_d = 1'b1;
          state_d = DONE;
          if (in_exp == EXP_ONES) begin
            exp_d = in_exp;
          end else if (in_man == RAW_ZERO) begin
            exp_d  = EXP_ZERO;
            man_d  = MAN_ZERO;
            zero_d = 1'b1;
          end else if (in_man[MAN_WIDTH+1]) begin
            if (carry_exp_s == EXP_ONES) begin
              exp_d = EXP_ONES;
              man_d = MAN_ZERO;
              ovf_d = 1'b1;
            end else begin
              exp_d = carry_exp_s;
              man_d = carry_man_s;
            end
          end else if (in_man[MAN_WIDTH]) begin
            // Two denormals can sum into a normal; the exponent field must become 1.
            if (in_exp == EXP_ZERO) begin
              exp_d = EXP_ONE;
            end else begin
              exp_d = in_exp;
            end
          end else if (in_exp <= EXP_ONE) begin
            exp_d = EXP_ZERO;
          end else begin
            valid_d = 1'b0;
            state_d = SHIFT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        man_d = shift_man_s;
        exp_d = shift_exp_s;
        if (shift_done_s) begin
          valid_d = 1'b1;
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        if (out_ready) begin
          valid_d = 1'b0;
          ovf_d   = 1'b0;
          zero_d  = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        valid_d = 1'b0;
        ovf_d   = 1'b0;
        zero_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      exp_q   <= EXP_ZERO;
      man_q   <= MAN_ZERO;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      man_q   <= man_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      valid_q <= valid_d;
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = valid_q;
  assign out_result   = {sign_q, exp_q, man_q[MAN_WIDTH-1:0]};
  assign out_overflow = ovf_q;
  assign out_zero     = zero_q;

endmodule

// File: tb/tb_float_normalize.sv
// Directed scoreboard bench for float_normalize (8-bit exponent, 7-bit fraction).
module tb_float_normalize;

`ifdef FLOAT_NORM_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  typedef struct {
    string       tag;
    logic [15:0] result;
    logic        ovf;
    logic        zero;
    int          lat;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [8:0]  in_man;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic        out_overflow;
  logic        out_zero;

  int   n_checks;
  int   n_fails;
  exp_t sb_q[$];

  float_normalize #(
    .EXP_WIDTH (8),
    .MAN_WIDTH (7)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sign      (in_sign),
    .in_exp       (in_exp),
    .in_man       (in_man),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_overflow (out_overflow),
    .out_zero     (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Drive one operation, wait for its result, compare against the scoreboard, then drain.
  task automatic run_op(input string tag, input logic s, input logic [7:0] e, input logic [8:0] m,
                        input logic [15:0] r, input logic ov, input logic z,
                        input int lat_it, input int lat_fast, input int hold);
    exp_t item;
    exp_t got;
    int   edges;
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = e;
    in_man   = m;
    item.tag    = tag;
    item.result = r;
    item.ovf    = ov;
    item.zero   = z;
    item.lat    = FAST ? lat_fast : lat_it;
    sb_q.push_back(item);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    edges    = 1;
    while (!out_valid && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check({tag, "_timeout"}, 32'(out_valid), 32'd1);
    got = sb_q.pop_front();
    check({got.tag, "_latency"}, 32'(edges), 32'(got.lat));
    check({got.tag, "_result"}, 32'(out_result), 32'(got.result));
    check({got.tag, "_ovf"}, 32'(out_overflow), 32'(got.ovf));
    check({got.tag, "_zero"}, 32'(out_zero), 32'(got.zero));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold_result"}, 32'(out_result), 32'(got.result));
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_drop_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_drop_flags"}, {30'd0, out_overflow, out_zero}, 32'd0);
    check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    n_checks  = 0;
    n_fails   = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = 8'h00;
    in_man    = 9'h000;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(out_result), 32'd0);
    check("rst_flags", {30'd0, out_overflow, out_zero}, 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    run_op("carry", 1'b0, 8'h80, 9'h180, 16'h40C0, 1'b0, 1'b0, 1, 1, 0);
    run_op("lshift", 1'b0, 8'h80, 9'h016, 16'h3EB0, 1'b0, 1'b0, 4, 2, 0);
    run_op("denorm_floor", 1'b0, 8'h02, 9'h004, 16'h0008, 1'b0, 1'b0, 3, 2, 0);
    run_op("overflow", 1'b1, 8'hFE, 9'h100, 16'hFF80, 1'b1, 1'b0, 1, 1, 0);
    run_op("inf_pass", 1'b0, 8'hFF, 9'h005, 16'h7F85, 1'b0, 1'b0, 1, 1, 0);
    run_op("zero_bp", 1'b1, 8'h37, 9'h000, 16'h8000, 1'b0, 1'b1, 1, 1, 3);
    run_op("den_to_norm", 1'b0, 8'h00, 9'h0C0, 16'h00C0, 1'b0, 1'b0, 1, 1, 0);
    run_op("den_exp1", 1'b0, 8'h01, 9'h030, 16'h0030, 1'b0, 1'b0, 1, 1, 0);
    run_op("carry_trunc", 1'b0, 8'h10, 9'h1FF, 16'h08FF, 1'b0, 1'b0, 1, 1, 0);
    run_op("worst_shift", 1'b0, 8'h80, 9'h001, 16'h3C80, 1'b0, 1'b0, 8, 2, 0);
    run_op("den_via_exp1", 1'b0, 8'h04, 9'h001, 16'h0008, 1'b0, 1'b0, 5, 2, 0);
    run_op("neg_shift1", 1'b1, 8'h80, 9'h040, 16'hBF80, 1'b0, 1'b0, 2, 2, 0);

    // Abort the left-shift case mid-normalisation with reset.
    @(negedge clk);
    in_valid = 1'b1;
    in_sign  = 1'b0;
    in_exp   = 8'h80;
    in_man   = 9'h016;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (!FAST) begin
      @(posedge clk);
      #1;
    end
    check("mid_pre_rst_valid", 32'(out_valid), 32'd0);
    check("mid_pre_rst_in_ready", 32'(in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_result", 32'(out_result), 32'd0);
    check("mid_rst_flags", {30'd0, out_overflow, out_zero}, 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_no_valid", 32'(out_valid), 32'd0);
    end
    run_op("after_rst", 1'b0, 8'h80, 9'h180, 16'h40C0, 1'b0, 1'b0, 1, 1, 0);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
